// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults and the controller state type for the
// time-multiplexed FIR MAC scheduler.
package fir_pkg;

  localparam int NTAPS_DEF   = 15;  // filter taps
  localparam int AW_DEF      = 4;   // $clog2(NTAPS_DEF)
  localparam int MAC_LAT_DEF = 2;   // address issue -> product accumulated

  typedef enum logic [2:0] {
    CLR,    // zero-filling sample history after reset
    IDLE,   // waiting for a sample or a host request
    CFG,    // host owns the coefficient RAM
    RUN,    // issuing one tap per cycle
    DRAIN,  // waiting for the MAC pipeline to empty
    HOLD    // presenting the result
  } state_e;

endpackage

// File: rtl/fir_addr_gen.sv
// fir_addr_gen: sample-ring address generation.
//   clk, reset  - clock, synchronous active-low reset
//   accept_i    - a sample is written at wptr_o this cycle
//   k_i         - current tap index during RUN
//   wptr_o      - ring write pointer (next free slot)
//   raddr_o     - (newest - k_i) mod NTAPS
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          accept_i,
  input  logic [AW-1:0] k_i,
  output logic [AW-1:0] wptr_o,
  output logic [AW-1:0] raddr_o
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);
  localparam logic [AW-1:0] NT_A     = AW'(NTAPS);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] newest_q, newest_d;

  always_comb begin
    wptr_d   = wptr_q;
    newest_d = newest_q;
    if (accept_i) begin
      newest_d = wptr_q;
      wptr_d   = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q   <= '0;
      newest_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      newest_q <= newest_d;
    end
  end

  // Wrap case: newest + NTAPS - k is below NTAPS, so AW-bit modular
  // arithmetic yields it exactly even when NTAPS == 2**AW.
  always_comb begin
    raddr_o = '0;
    if (newest_q >= k_i) raddr_o = newest_q - k_i;
    else                 raddr_o = newest_q + NT_A - k_i;
  end

  assign wptr_o = wptr_q;

endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: controller for a shared-MAC FIR engine.
//   s_valid/s_ready           - input sample handshake
//   smp_we/wsel/waddr/raddr   - sample ring RAM control (wsel=1 writes zero)
//   coef_raddr                - coefficient read address during RUN
//   mac_en/mac_clr            - tap valid / first tap (datapath delays by MAC_LAT)
//   m_valid/m_ready           - result handshake
//   cfg_req/gnt/we/addr       - host coefficient port
//   coef_we/coef_waddr        - coefficient RAM write
//   cfg_err                   - out-of-range host write
//   busy                      - state != IDLE
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int NTAPS   = NTAPS_DEF,
  parameter int AW      = AW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          smp_we,
  output logic          smp_wsel,
  output logic [AW-1:0] smp_waddr,
  output logic [AW-1:0] smp_raddr,
  output logic [AW-1:0] coef_raddr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic          cfg_req,
  output logic          cfg_gnt,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  output logic          coef_we,
  output logic [AW-1:0] coef_waddr,
  output logic          cfg_err,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_TAP   = AW'(NTAPS - 1);
  localparam logic [AW-1:0] DRAIN_LAST = AW'(MAC_LAT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;     // clear index, tap index k, drain count
  logic          active_q;         // low while reset is held: outputs forced 0
  logic          accept;
  logic          addr_ok;
  logic [AW-1:0] wptr, rd_addr;

  assign addr_ok = ({1'b0, cfg_addr} < (AW+1)'(NTAPS));

  fir_addr_gen #(
    .NTAPS (NTAPS),
    .AW    (AW)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .accept_i (accept),
    .k_i      (cnt_q),
    .wptr_o   (wptr),
    .raddr_o  (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= CLR;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    s_ready    = 1'b0;
    smp_we     = 1'b0;
    smp_wsel   = 1'b0;
    smp_waddr  = '0;
    smp_raddr  = '0;
    coef_raddr = '0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    m_valid    = 1'b0;
    cfg_gnt    = 1'b0;
    coef_we    = 1'b0;
    coef_waddr = '0;
    cfg_err    = 1'b0;
    busy       = 1'b0;
    if (active_q) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        CLR: begin
          smp_we    = 1'b1;
          smp_wsel  = 1'b1;
          smp_waddr = cnt_q;
          if (cnt_q == LAST_TAP) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        IDLE: begin
          s_ready = 1'b1;
          if (s_valid) begin
            accept    = 1'b1;
            smp_we    = 1'b1;
            smp_waddr = wptr;
            cnt_d     = '0;
            state_d   = RUN;
          end else if (cfg_req) begin
            // Grant is combinational on the request, so the host owns the
            // RAM from the first IDLE cycle that no sample competes with it.
            cfg_gnt    = 1'b1;
            coef_waddr = cfg_addr;
            coef_we    = cfg_we & addr_ok;
            cfg_err    = cfg_we & ~addr_ok;
            state_d    = CFG;
          end
        end
        CFG: begin
          cfg_gnt    = cfg_req;
          coef_waddr = cfg_addr;
          coef_we    = cfg_req & cfg_we & addr_ok;
          cfg_err    = cfg_req & cfg_we & ~addr_ok;
          if (!cfg_req) state_d = IDLE;
        end
        RUN: begin
          mac_en     = 1'b1;
          mac_clr    = (cnt_q == '0);
          coef_raddr = cnt_q;
          smp_raddr  = rd_addr;
          if (cnt_q == LAST_TAP) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          m_valid = 1'b1;
          if (m_ready) state_d = IDLE;
        end
        default: state_d = CLR;
      endcase
    end
  end

endmodule
